mem_arbiter: RTL and testbench

Shares the single simulation RAM port pair (write: waddr/wdata/we, read: raddr/re/rdata) among NPORT requesters, e.g. instruction fetch, data load/store and a debug/DMA port. Grants at most one access per cycle using round-robin priority, with an optional lock for back-to-back sequences such as read-modify-write. Routes read data back to the originating port with a one-cycle valid strobe. Sits between the CPU/peripheral masters and simram.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the simulation RAM arbiter.
// Port indices are sized for the largest supported requester count.
package mem_arb_pkg;

  localparam int MAX_NPORT = 4;
  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int IW        = $clog2(MAX_NPORT);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [0:0] {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic idx_t wrap_inc(idx_t i, int n);
    return (int'(i) >= n - 1) ? '0 : idx_t'(int'(i) + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Produces a one-hot grant, the winner index and an any-grant flag.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic [N-1:0] gnt,
  output idx_t         idx,
  output logic         any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] &&
            j == (int'(ptr) + k) % N) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock, sharing one simram port pair
// among NPORT requesters; read data returns one cycle after grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NPORT-1:0]          req,
  input  logic [NPORT-1:0]          lock,
  input  logic [NPORT-1:0]          wr,
  input  logic [NPORT-1:0][AW-1:0]  addr,
  input  logic [NPORT-1:0][DW-1:0]  wdata,
  output logic [NPORT-1:0]          gnt,
  output logic [NPORT-1:0]          rvalid,
  output logic [DW-1:0]             rdata,
  output logic [AW-1:0]             mem_waddr,
  output logic [DW-1:0]             mem_wdata,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_raddr,
  output logic                      mem_re,
  input  logic [DW-1:0]             mem_rdata
);

  state_e state;
  idx_t   owner;
  idx_t   rr_ptr;
  logic   tag_v;
  idx_t   tag_idx;

  logic [NPORT-1:0] own_oh;
  logic [NPORT-1:0] pick_req;
  logic [NPORT-1:0] pick_gnt;
  idx_t             pick_ptr;
  idx_t             pick_idx;
  logic             pick_any;
  logic             hold;
  logic             issue;
  logic             win_wr;
  logic             win_lock;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;

  always_comb begin
    own_oh = '0;
    for (int j = 0; j < NPORT; j++) begin
      own_oh[j] = (owner == idx_t'(j));
    end
  end

  // A requesting owner masks everyone else; otherwise arbitrate from owner+1.
  assign hold     = (state == ST_LOCKED) && |(own_oh & req);
  assign pick_req = hold ? own_oh : req;
  assign pick_ptr = (state == ST_LOCKED) ?
                    wrap_inc(owner, NPORT) : rr_ptr;

  rr_pick #(
    .N(NPORT)
  ) u_pick (
    .req(pick_req),
    .ptr(pick_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign issue = pick_any & reset_n;
  assign gnt   = issue ? pick_gnt : '0;

  always_comb begin
    win_wr    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (pick_gnt[j]) begin
        win_wr    = wr[j];
        win_lock  = lock[j];
        win_addr  = addr[j];
        win_wdata = wdata[j];
      end
    end
  end

  assign mem_we    = issue & win_wr;
  assign mem_re    = issue & ~win_wr;
  assign mem_waddr = mem_we ? win_addr : '0;
  assign mem_wdata = mem_we ? win_wdata : '0;
  assign mem_raddr = mem_re ? win_addr : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RR;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (pick_any) begin
      rr_ptr <= wrap_inc(pick_idx, NPORT);
      owner  <= pick_idx;
      state  <= win_lock ? ST_LOCKED : ST_RR;
    end else if (state == ST_LOCKED) begin
      rr_ptr <= wrap_inc(owner, NPORT);
      state  <= ST_RR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v   <= 1'b0;
      tag_idx <= '0;
    end else begin
      tag_v <= mem_re;
      if (mem_re) begin
        tag_idx <= pick_idx;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int j = 0; j < NPORT; j++) begin
      rvalid[j] = tag_v && (tag_idx == idx_t'(j));
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table and corner sequences on a 2-port
// instance, wrap-around and randomized model checks on a 4-port one.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // 2-port instance
  logic [1:0]       req2, lock2, wr2, gnt2, rvalid2;
  logic [1:0][15:0] addr2, wdata2;
  logic [15:0]      rdata2, waddr2, mwdata2, raddr2, mrdata2;
  logic             we2, re2;
  logic [15:0]      mem2 [0:255];

  mem_arbiter #(.NPORT(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req(req2), .lock(lock2), .wr(wr2),
    .addr(addr2), .wdata(wdata2),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
    .mem_waddr(waddr2), .mem_wdata(mwdata2), .mem_we(we2),
    .mem_raddr(raddr2), .mem_re(re2), .mem_rdata(mrdata2)
  );

  always @(posedge clk) begin
    if (we2) mem2[waddr2[7:0]] <= mwdata2;
    if (re2) mrdata2 <= mem2[raddr2[7:0]];
  end

  // 4-port instance
  logic [3:0]       req4, lock4, wr4, gnt4, rvalid4;
  logic [3:0][15:0] addr4, wdata4;
  logic [15:0]      rdata4, waddr4, mwdata4, raddr4, mrdata4;
  logic             we4, re4;
  logic [15:0]      mem4 [0:255];

  mem_arbiter #(.NPORT(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req(req4), .lock(lock4), .wr(wr4),
    .addr(addr4), .wdata(wdata4),
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
    .mem_waddr(waddr4), .mem_wdata(mwdata4), .mem_we(we4),
    .mem_raddr(raddr4), .mem_re(re4), .mem_rdata(mrdata4)
  );

  always @(posedge clk) begin
    if (we4) mem4[waddr4[7:0]] <= mwdata4;
    if (re4) mrdata4 <= mem4[raddr4[7:0]];
  end

  typedef struct {
    logic [1:0]  req, lock, wr;
    logic [15:0] a0, a1, wd;
    logic [1:0]  gnt;
    logic        we, re;
    logic [15:0] maddr;
    logic [1:0]  rv;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [1:0] rq, logic [1:0] lk, logic [1:0] w,
                     logic [15:0] a0, logic [15:0] a1, logic [15:0] wd,
                     logic [1:0] g, logic we, logic re,
                     logic [15:0] ma, logic [1:0] rv, logic [15:0] rd);
    vec_t v;
    v.req = rq; v.lock = lk; v.wr = w;
    v.a0 = a0; v.a1 = a1; v.wd = wd;
    v.gnt = g; v.we = we; v.re = re;
    v.maddr = ma; v.rv = rv; v.rd = rd;
    tbl.push_back(v);
  endtask

  // reference model state for the 4-port random run
  logic [15:0] mdl [0:255];
  int m_ptr, m_owner, exp_rv, nxt_rv, win, start, p;
  bit m_locked;
  logic [15:0] exp_rd, nxt_rd;
  logic [3:0]  eg;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem2[i] = '0; mem4[i] = '0; mdl[i] = '0;
    end
    reset_n = 1'b0;
    req2 = 2'b11; lock2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0;
    req4 = 4'hf;  lock4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
    #2;
    chk("rst_gnt2", gnt2, 0);
    chk("rst_we2", we2, 0);
    chk("rst_re2", re2, 0);
    chk("rst_rv2", rvalid2, 0);
    chk("rst_gnt4", gnt4, 0);
    chk("rst_rv4", rvalid4, 0);
    req2 = '0; req4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    //  req   lock  wr    a0      a1      wd       gnt   we re maddr   rv    rd
    add(2'b01,2'b00,2'b01,16'h10, 16'h0,  16'hBEEF,2'b01,1,0,16'h10, 2'b00,16'h0);
    add(2'b01,2'b00,2'b00,16'h10, 16'h0,  16'h0,   2'b01,0,1,16'h10, 2'b00,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,  16'h0,  16'h0,   2'b00,0,0,16'h0,  2'b01,16'hBEEF);
    add(2'b01,2'b00,2'b01,16'h1,  16'h0,  16'h1111,2'b01,1,0,16'h1,  2'b00,16'h0);
    add(2'b10,2'b00,2'b10,16'h0,  16'h2,  16'h2222,2'b10,1,0,16'h2,  2'b00,16'h0);
    add(2'b11,2'b00,2'b00,16'h1,  16'h2,  16'h0,   2'b01,0,1,16'h1,  2'b00,16'h0);
    add(2'b11,2'b00,2'b00,16'h1,  16'h2,  16'h0,   2'b10,0,1,16'h2,  2'b01,16'h1111);
    add(2'b11,2'b00,2'b00,16'h1,  16'h2,  16'h0,   2'b01,0,1,16'h1,  2'b10,16'h2222);
    add(2'b11,2'b00,2'b00,16'h1,  16'h2,  16'h0,   2'b10,0,1,16'h2,  2'b01,16'h1111);
    add(2'b01,2'b00,2'b00,16'h1,  16'h2,  16'h0,   2'b01,0,1,16'h1,  2'b10,16'h2222);
    add(2'b11,2'b10,2'b00,16'h1,  16'h20, 16'h0,   2'b10,0,1,16'h20, 2'b01,16'h1111);
    add(2'b11,2'b10,2'b10,16'h1,  16'h20, 16'h1234,2'b10,1,0,16'h20, 2'b10,16'h0);
    add(2'b11,2'b00,2'b00,16'h1,  16'h20, 16'h0,   2'b10,0,1,16'h20, 2'b00,16'h0);
    add(2'b01,2'b00,2'b00,16'h1,  16'h20, 16'h0,   2'b01,0,1,16'h1,  2'b10,16'h1234);
    add(2'b00,2'b00,2'b00,16'h0,  16'h0,  16'h0,   2'b00,0,0,16'h0,  2'b01,16'h1111);
    add(2'b10,2'b10,2'b10,16'h0,  16'h30, 16'h5555,2'b10,1,0,16'h30, 2'b00,16'h0);
    add(2'b01,2'b00,2'b00,16'h30, 16'h30, 16'h0,   2'b01,0,1,16'h30, 2'b00,16'h0);
    add(2'b11,2'b00,2'b00,16'h10, 16'h10, 16'h0,   2'b10,0,1,16'h10, 2'b01,16'h5555);
    add(2'b00,2'b00,2'b00,16'h0,  16'h0,  16'h0,   2'b00,0,0,16'h0,  2'b10,16'hBEEF);

    foreach (tbl[i]) begin
      req2 = tbl[i].req; lock2 = tbl[i].lock; wr2 = tbl[i].wr;
      addr2[0] = tbl[i].a0; addr2[1] = tbl[i].a1;
      wdata2[0] = tbl[i].wd; wdata2[1] = tbl[i].wd;
      #2;
      chk($sformatf("v%0d_gnt", i), gnt2, tbl[i].gnt);
      chk($sformatf("v%0d_we", i), we2, tbl[i].we);
      chk($sformatf("v%0d_re", i), re2, tbl[i].re);
      chk($sformatf("v%0d_waddr", i), waddr2,
          tbl[i].we ? tbl[i].maddr : 16'h0);
      chk($sformatf("v%0d_wdata", i), mwdata2,
          tbl[i].we ? tbl[i].wd : 16'h0);
      chk($sformatf("v%0d_raddr", i), raddr2,
          tbl[i].re ? tbl[i].maddr : 16'h0);
      chk($sformatf("v%0d_rvalid", i), rvalid2, tbl[i].rv);
      if (tbl[i].rv != 2'b00)
        chk($sformatf("v%0d_rdata", i), rdata2, tbl[i].rd);
      @(posedge clk); #1;
    end

    // lock then reset mid-cycle with a read in flight
    req2 = 2'b10; lock2 = 2'b10; wr2 = '0; addr2[1] = 16'h10;
    #2 chk("pre_rst_gnt", gnt2, 2'b10);
    @(posedge clk); #1;
    req2 = 2'b11;
    #1;
    chk("pre_rst_hold", gnt2, 2'b10);
    chk("pre_rst_rv", rvalid2, 2'b10);
    chk("pre_rst_rd", rdata2, 16'hBEEF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt2, 2'b00);
    chk("mid_rst_re", re2, 0);
    chk("mid_rst_rv", rvalid2, 2'b00);
    @(posedge clk);
    @(negedge clk);
    lock2 = 2'b00; reset_n = 1'b1;
    #1;
    chk("post_rst_gnt", gnt2, 2'b01);
    chk("post_rst_norv", rvalid2, 2'b00);
    @(posedge clk); #1;
    chk("post_rst_rv", rvalid2, 2'b01);
    req2 = '0;

    // 4-port wrap-around: grant port 1 so the pointer sits at 2
    req4 = 4'b0010; wr4 = '0; addr4[1] = 16'h5; addr4[3] = 16'h6;
    #2 chk("w4_g1", gnt4, 4'b0010);
    @(posedge clk); #1;
    req4 = 4'b1010;
    #2;
    chk("w4_g3", gnt4, 4'b1000);
    chk("w4_rv1", rvalid4, 4'b0010);
    @(posedge clk); #1;
    #2;
    chk("w4_g1b", gnt4, 4'b0010);
    chk("w4_rv3", rvalid4, 4'b1000);
    @(posedge clk); #1;
    req4 = '0;
    #2 chk("w4_rv1b", rvalid4, 4'b0010);
    @(posedge clk); #1;

    // randomized run against a behavioural model
    m_ptr = 2; m_locked = 0; m_owner = 0; exp_rv = -1; exp_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req4[i] && $urandom_range(0, 1) == 1) begin
          req4[i]   = 1'b1;
          wr4[i]    = 1'($urandom);
          lock4[i]  = ($urandom_range(0, 3) == 0);
          addr4[i]  = 16'($urandom_range(0, 15));
          wdata4[i] = 16'($urandom);
        end
      end
      #2;
      win = -1;
      if (m_locked && req4[m_owner]) begin
        win = m_owner;
      end else begin
        start = m_locked ? (m_owner + 1) % 4 : m_ptr;
        for (int k = 0; k < 4; k++) begin
          p = (start + k) % 4;
          if (win < 0 && req4[p]) win = p;
        end
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      chk("r_gnt", gnt4, eg);
      chk("r_we", we4, (win >= 0) && wr4[win]);
      chk("r_re", re4, (win >= 0) && !wr4[win]);
      chk("r_waddr", waddr4,
          ((win >= 0) && wr4[win]) ? addr4[win] : 16'h0);
      chk("r_raddr", raddr4,
          ((win >= 0) && !wr4[win]) ? addr4[win] : 16'h0);
      chk("r_rvalid", rvalid4,
          (exp_rv >= 0) ? (32'd1 << exp_rv) : 32'd0);
      if (exp_rv >= 0) chk("r_rdata", rdata4, exp_rd);
      nxt_rv = -1; nxt_rd = '0;
      if (win >= 0) begin
        if (wr4[win]) begin
          mdl[addr4[win][7:0]] = wdata4[win];
        end else begin
          nxt_rv = win;
          nxt_rd = mdl[addr4[win][7:0]];
        end
        m_ptr    = (win + 1) % 4;
        m_locked = lock4[win];
        m_owner  = win;
      end else if (m_locked) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % 4;
      end
      @(posedge clk); #1;
      if (win >= 0) req4[win] = 1'b0;
      exp_rv = nxt_rv;
      exp_rd = nxt_rd;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
